// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo tester: parity modes,
// FSM state encodings and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  // Data is zero-extended to 9 bits; the padding does not alter the xor.
  function automatic logic parity_bit(input logic [8:0] d,
                                      input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_echo_tester_if.sv
// Echo buffer port bundle between the receive/transmit logic and the FIFO.
interface uart_echo_tester_if #(
  parameter int W = 8
);
  logic         push;
  logic         pop;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         full;
  logic         empty;

  modport master (
    output push, pop, wdata,
    input  rdata, full, empty
  );

  modport slave (
    input  push, pop, wdata,
    output rdata, full, empty
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word fall-through echo buffer; a push while full is accepted
// only when the same cycle also pops.
module uart_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clock,
  input logic               reset,
  uart_echo_tester_if.slave f
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign f.full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign f.empty = (cnt_q == '0);
  assign f.rdata = mem_q[rd_q];

  always_comb begin
    do_pop  = f.pop && !f.empty;
    do_push = f.push && (!f.full || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= f.wdata;
  end

endmodule

// File: rtl/uart_echo_tester.sv
// Board UART echo tester: receive, check, buffer and retransmit frames,
// reporting errors on led1/err_count and good traffic on led2.
module uart_echo_tester
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       tx_hold,
  output logic       tx,
  output logic       led1,
  output logic       led2,
  output logic [7:0] err_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam bit            HAS_PAR  = (PARITY != PAR_NONE);

  function automatic logic [8:0] ext9(input logic [DATA_BITS-1:0] d);
    logic [8:0] r;
    r = '0;
    r[DATA_BITS-1:0] = d;
    return r;
  endfunction

  uart_echo_tester_if #(.W(DATA_BITS)) fifo_if ();

  uart_sync_fifo #(
    .WIDTH     (DATA_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .f    (fifo_if)
  );

  logic                 rx_s1_q, rx_s2_q;
  rx_state_e            rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_wait_q, rx_wait_d;
  logic                 rx_err;
  logic                 led1_q, led1_d;
  logic                 led2_q, led2_d;
  logic [7:0]           err_q, err_d;

  tx_state_e            tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_pb_q, tx_pb_d;
  logic                 tx_q, tx_d;
  logic                 tx_go;

  assign tx        = tx_q;
  assign led1      = led1_q;
  assign led2      = led2_q;
  assign err_count = err_q;

  always_comb begin
    rx_st_d        = rx_st_q;
    rx_cnt_d       = rx_cnt_q + 1'b1;
    rx_idx_d       = rx_idx_q;
    rx_sh_d        = rx_sh_q;
    rx_par_d       = rx_par_q;
    rx_wait_d      = rx_wait_q;
    rx_err         = 1'b0;
    led1_d         = led1_q;
    led2_d         = led2_q;
    err_d          = err_q;
    fifo_if.push   = 1'b0;
    fifo_if.wdata  = rx_sh_q;
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // After a framing error the line must return high first.
        if (rx_wait_q) begin
          if (rx_s2_q) rx_wait_d = 1'b0;
        end else if (!rx_s2_q) begin
          rx_st_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
          rx_idx_d = rx_idx_q + 1'b1;
          if (rx_idx_q == LAST_BIT)
            rx_st_d = HAS_PAR ? RX_PAR : RX_STOP;
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_par_d = rx_s2_q;
          rx_st_d  = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          if (!rx_s2_q) begin
            rx_err    = 1'b1;
            rx_wait_d = 1'b1;
          end else if (HAS_PAR &&
                       rx_par_q != parity_bit(ext9(rx_sh_q), PARITY)) begin
            rx_err = 1'b1;
          end else if (fifo_if.full && !fifo_if.pop) begin
            rx_err = 1'b1;
          end else begin
            fifo_if.push = 1'b1;
            led2_d       = !led2_q;
          end
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
    if (rx_err) begin
      led1_d = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_comb begin
    tx_st_d     = tx_st_q;
    tx_cnt_d    = tx_cnt_q + 1'b1;
    tx_idx_d    = tx_idx_q;
    tx_sh_d     = tx_sh_q;
    tx_pb_d     = tx_pb_q;
    tx_d        = tx_q;
    fifo_if.pop = 1'b0;
    tx_go       = !fifo_if.empty && !tx_hold;
    unique case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (tx_go) begin
          fifo_if.pop = 1'b1;
          tx_sh_d     = fifo_if.rdata;
          tx_pb_d     = parity_bit(ext9(fifo_if.rdata), PARITY);
          tx_st_d     = TX_START;
          tx_d        = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_idx_d = '0;
          tx_st_d  = TX_DATA;
          tx_d     = tx_sh_q[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_BIT) begin
            tx_st_d = HAS_PAR ? TX_PAR : TX_STOP;
            tx_d    = HAS_PAR ? tx_pb_q : 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_q[1];
          end
        end
      end
      TX_PAR: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          tx_st_d  = TX_STOP;
          tx_d     = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (tx_go) begin
            fifo_if.pop = 1'b1;
            tx_sh_d     = fifo_if.rdata;
            tx_pb_d     = parity_bit(ext9(fifo_if.rdata), PARITY);
            tx_st_d     = TX_START;
            tx_d        = 1'b0;
          end else begin
            tx_st_d = TX_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      rx_par_q  <= 1'b0;
      rx_wait_q <= 1'b0;
      led1_q    <= 1'b0;
      led2_q    <= 1'b0;
      err_q     <= '0;
      tx_st_q   <= TX_IDLE;
      tx_cnt_q  <= '0;
      tx_idx_q  <= '0;
      tx_sh_q   <= '0;
      tx_pb_q   <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_par_q  <= rx_par_d;
      rx_wait_q <= rx_wait_d;
      led1_q    <= led1_d;
      led2_q    <= led2_d;
      err_q     <= err_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      tx_sh_q   <= tx_sh_d;
      tx_pb_q   <= tx_pb_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Scoreboard bench: frames are driven on rx, expected echoes queued,
// and a line monitor decodes tx and compares against the queue.
module tb_uart_echo_tester;

  localparam int CPB = 16;
  localparam int FD  = 4;
  localparam int LAT = 2 + CPB / 2 + CPB * 9 + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_hold;
  logic       rx_drv;
  bit         par_phase;
  logic       rx_a, rx_b, tx_a, tx_b;
  logic       l1a, l2a, l1b, l2b;
  logic [7:0] ea, eb;
  logic       tx_m, l1_m, l2_m;
  logic [7:0] e_m;

  always #5 clk = ~clk;

  assign rx_a = par_phase ? 1'b1 : rx_drv;
  assign rx_b = par_phase ? rx_drv : 1'b1;
  assign tx_m = par_phase ? tx_b : tx_a;
  assign l1_m = par_phase ? l1b : l1a;
  assign l2_m = par_phase ? l2b : l2a;
  assign e_m  = par_phase ? eb : ea;

  uart_echo_tester #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(FD)
  ) u_a (
    .clock(clk), .reset(reset), .rx(rx_a), .tx_hold(tx_hold),
    .tx(tx_a), .led1(l1a), .led2(l2a), .err_count(ea)
  );

  uart_echo_tester #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(FD)
  ) u_b (
    .clock(clk), .reset(reset), .rx(rx_b), .tx_hold(tx_hold),
    .tx(tx_b), .led1(l1b), .led2(l2b), .err_count(eb)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames_seen = 0;
  int         ref_err = 0;
  bit         ref_led2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int         mt = 0;
  bit         mbusy = 1'b0;
  logic [11:0] mbits;

  task automatic score();
    int         nb;
    logic [7:0] d, e;
    nb = par_phase ? 11 : 10;
    d  = mbits[8:1];
    check("start_bit", int'(mbits[0]), 0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_frame: got data %0h, expected none", d);
    end else begin
      e = exp_q.pop_front();
      check("echo_data", int'(d), int'(e));
      if (par_phase)
        check("echo_parity", int'(mbits[9]), $countones(e) % 2);
    end
    check("stop_bit", int'(mbits[4'(nb - 1)]), 1);
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mbusy = 1'b0;
    end else if (!mbusy) begin
      if (tx_m == 1'b0) begin
        mbusy = 1'b1;
        mt    = 0;
        starts.push_back(cyc);
        frames_seen++;
      end
    end else begin
      mt++;
    end
    if (mbusy && (mt % CPB) == CPB / 2) begin
      mbits[4'(mt / CPB)] = tx_m;
      if (mt / CPB == (par_phase ? 10 : 9)) begin
        mbusy = 1'b0;
        score();
      end
    end
  end

  task automatic idle(input int n);
    rx_drv = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_bit(input logic b);
    rx_drv = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit bad_par,
                      input bit bad_stop, output int k);
    logic [7:0] s;
    bit         pb;
    s  = d;
    k  = cyc;
    pb = ($countones(d) % 2 == 1) ^ bad_par;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      hold_bit(s[0]);
      s = s >> 1;
    end
    if (par_phase) hold_bit(pb);
    hold_bit(!bad_stop);
    if (bad_stop || (par_phase && bad_par)) ref_err++;
    else if (exp_q.size() >= FD) ref_err++;
    else begin
      exp_q.push_back(d);
      ref_led2 = !ref_led2;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !mbusy) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    check("echo_drained", exp_q.size() + int'(mbusy), 0);
  endtask

  task automatic status(input string tag);
    check({tag, "_err_count"}, int'(e_m), ref_err);
    check({tag, "_led1"}, int'(l1_m), int'(ref_err != 0));
    check({tag, "_led2"}, int'(l2_m), int'(ref_led2));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset    = 1'b1;
    ref_err  = 0;
    ref_led2 = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int k, fs;
    reset     = 1'b0;
    tx_hold   = 1'b0;
    rx_drv    = 1'b1;
    par_phase = 1'b0;
    do_reset();
    check("reset_tx", int'(tx_m), 1);
    check("reset_tx_b", int'(tx_b), 1);
    status("reset");
    idle(5);

    // basic echo with start-bit latency
    send(8'h55, 1'b0, 1'b0, k);
    drain(400);
    check("basic_frames", frames_seen, 1);
    if (starts.size() > 0)
      check("basic_latency", starts[starts.size() - 1] - k, LAT);
    status("basic");

    // overrun while transmit is held
    tx_hold = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), 1'b0, 1'b0, k);
      idle(3);
    end
    status("overrun");
    starts.delete();
    tx_hold = 1'b0;
    drain(1200);
    check("overrun_frames", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++)
      check("back_to_back_gap", starts[i] - starts[i - 1], CPB * 10);

    // framing error then good character
    send(8'hA5, 1'b0, 1'b1, k);
    idle(5);
    send(8'h3C, 1'b0, 1'b0, k);
    drain(400);
    status("framing");

    for (int n = 0; n < 16; n++) begin
      idle($urandom_range(2, 40));
      send(8'($urandom), 1'b0, $urandom_range(0, 7) == 0, k);
      drain(400);
    end
    status("random_a");

    // short low pulse must be ignored
    fs = frames_seen;
    rx_drv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(60);
    check("glitch_frames", frames_seen, fs);
    status("glitch");

    // reset in the middle of a transmitted frame
    tx_hold = 1'b1;
    send(8'h5A, 1'b0, 1'b0, k);
    send(8'h66, 1'b0, 1'b0, k);
    idle(4);
    tx_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mbusy && mt >= CPB * 4) break;
      @(posedge clk);
    end
    #1;
    check("reset_mid_reached", int'(mbusy), 1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid_tx", int'(tx_m), 1);
    check("reset_mid_err", int'(e_m), 0);
    check("reset_mid_led1", int'(l1_m), 0);
    check("reset_mid_led2", int'(l2_m), 0);
    reset    = 1'b1;
    ref_err  = 0;
    ref_led2 = 1'b0;
    exp_q.delete();
    fs = frames_seen;
    idle(CPB * 30);
    check("reset_mid_no_frame", frames_seen, fs);
    status("after_reset");

    // even parity instance
    par_phase = 1'b1;
    do_reset();
    idle(5);
    status("par_reset");
    send(8'h03, 1'b1, 1'b0, k);
    idle(5);
    status("par_bad");
    send(8'h03, 1'b0, 1'b0, k);
    drain(400);
    status("par_good");
    for (int n = 0; n < 10; n++) begin
      idle($urandom_range(2, 40));
      send(8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, k);
      drain(400);
    end
    status("random_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_echo_tester.md
# uart_echo_tester

Parametrised on-board UART echo tester: receives serial frames on `rx`, checks framing and parity, buffers good characters in a small FIFO, and retransmits them on `tx` with identical frame format. Errors are counted and latched onto a status LED, and good-character activity is shown on a second LED. It sits at the FPGA top level between the board UART pins and LEDs. It is the board bring-up test for the serial link and the reference consumer of the UART receive/transmit logic.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit. Must be ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. Range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `FIFO_DEPTH`, default 16: echo buffer entries. Power of 2, ≥ 2.
- `clock`, in, 1: single clock. All logic is on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `rx`, in, 1: serial input. Asynchronous to `clock`; idle high.
- `tx_hold`, in, 1: while high, no new transmit frame starts. A frame already in progress completes.
- `tx`, out, 1: serial output, idle high.
- `led1`, out, 1: sticky error flag.
- `led2`, out, 1: toggles once per good character written to the FIFO.
- `err_count`, out, 8: total errors (framing, parity and overrun), saturating at 255.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer. All receive logic uses the synchronized value.
- **Receive FSM states:** RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP.
  - RX_IDLE → RX_START when the synchronized `rx` is low.
  - In RX_START, `rx` is sampled after CLKS_PER_BIT/2 cycles (integer division). If it is high, the event is a glitch: return to RX_IDLE with no error.
  - RX_DATA takes DATA_BITS samples, LSB first, one every CLKS_PER_BIT cycles.
  - RX_PAR is skipped when PARITY = 0.
  - RX_STOP takes one sample, then returns to RX_IDLE.
- **Receive error handling:**
  - Stop sample = 0: framing error, character discarded. The FSM returns to RX_IDLE and waits for `rx` high before accepting a new start bit.
  - Parity mismatch: parity error, character discarded. When both errors occur on the same character, one error is counted.
  - A good character arriving while the FIFO is full is an overrun error and the character is discarded. If the same cycle also pops, the push is accepted.
- **Transmit FSM states:** TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP.
  - TX_IDLE pops the FIFO when it is not empty and `tx_hold` = 0.
  - The frame is sent as: start 0, data LSB first, parity (if enabled), one stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- **Parity calculation:** odd parity bit = ~^data; even parity bit = ^data.
- **Error reporting:** any error sets `led1` (cleared only by reset) and increments `err_count`, saturating at 255.

## Timing
- **Reset values:** `tx` = 1, `led1` = 0, `led2` = 0, `err_count` = 0, FIFO empty, both FSMs idle.
- **Reset mid-frame:** a partial frame in either direction is abandoned. `tx` is high in the cycle after `reset` is sampled low.
- **Latency (rx to tx):** cycle S is the cycle in which the stop sample is judged.
  - FIFO write and `led2` toggle happen on the edge ending cycle S.
  - If `tx` was idle and `tx_hold` = 0, `tx` goes low (start bit) in cycle S+2.
- **Synchronizer delay:** `rx` edges are seen 2 cycles late. All sample points are measured from the synchronized falling edge.
- **FIFO boundaries:**
  - Pop on empty never occurs.
  - Push on empty is visible to the transmitter in the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- **Back-to-back transmit:** consecutive frames are emitted with no idle bits between them when the FIFO has data.

## Structure
- **Shared package `uart_pkg`:**
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN;
  - receive and transmit state encodings;
  - a function for the parity bit.
- **Sub-module `uart_sync_fifo`:** parametrised by width (DATA_BITS) and FIFO_DEPTH.
  - Ports: push/pop, `full`, `empty`, and read data.
  - Read data is valid in the same cycle as `empty` = 0 (first-word fall-through).
- **Top level:** the receive and transmit FSMs stay in `uart_echo_tester`.

## Test plan
All scenarios use CLKS_PER_BIT = 16, DATA_BITS = 8, FIFO_DEPTH = 4, and PARITY = 0 unless stated otherwise.
1. **Basic echo:** send 0x55 → `tx` carries an identical 0x55 frame starting at cycle S+2; `led2` = 1, `led1` = 0, `err_count` = 0.
2. **Overrun:** hold `tx_hold` = 1, send 0x01..0x06, then release → echoed 0x01, 0x02, 0x03, 0x04 in order, back-to-back; `err_count` = 2, `led1` = 1.
3. **Framing error:** send 0xA5 with stop bit 0, then 0x3C normally → only 0x3C echoed; `err_count` = 1, `led1` = 1.
4. **Glitch rejection:** drive `rx` low for 4 cycles, then high → no FIFO write, no `tx` activity, `err_count` = 0.
5. **Parity (PARITY = 2, even):**
   - 0x03 with parity bit 1 → discarded, `err_count` = 1.
   - 0x03 with parity bit 0 → echoed with parity bit 0.
6. **Reset mid-frame:** assert `reset` low mid-way through the data bits of a `tx` frame → `tx` = 1 in the next cycle, FIFO empty, `led1`/`led2`/`err_count` = 0, and no further frame is transmitted.
